// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes a sampled code to a phase index, checks step legality,
// tracks lock and counts errors. Define JDEC_STALL_TIMEOUT_EN to drop lock after STALL_LIMIT holds.
module johnson_decoder #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        In_valid,
  input  logic [WIDTH-1:0]            Q_in,
  output logic [$clog2(2*WIDTH)-1:0]  Count,
  output logic                        Count_valid,
  output logic                        Dir,
  output logic                        Illegal_code,
  output logic                        Seq_error,
  output logic                        Locked,
  output logic [7:0]                  Err_count
);

  localparam int unsigned NPH = 2 * WIDTH;
  localparam int unsigned IW  = $clog2(NPH);
  localparam int unsigned PW  = $clog2(WIDTH + 1);
  localparam int unsigned SW  = $clog2(LOCK_COUNT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NPH - 1);

  localparam logic [1:0] UNLOCKED = 2'd0;
  localparam logic [1:0] TRACKING = 2'd1;
  localparam logic [1:0] LOCKED   = 2'd2;

  if (WIDTH < 2 || LOCK_COUNT < 1 || STALL_LIMIT < 1) begin : g_param_check
    $error("johnson_decoder: WIDTH>=2, LOCK_COUNT>=1 and STALL_LIMIT>=1 required");
  end

  logic [1:0]       state, state_nxt;
  logic [SW-1:0]    step_cnt, step_nxt;
  logic [IW-1:0]    count_nxt;
  logic             cvalid_nxt, dir_nxt, ill_nxt, seq_nxt, err_inc;

  logic [PW-1:0]    pop;
  logic [WIDTH-1:0] low_ones, high_ones;
  logic             code_ok;
  logic [IW-1:0]    idx, idx_fwd, idx_rev;
  logic             is_fwd, is_rev, is_hold;

`ifdef JDEC_STALL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(STALL_LIMIT + 1);
  logic [TW-1:0]    stall_cnt, stall_nxt;
`endif

  // Decode: the only legal codes are a run of ones from the LSB (MSB=0) or from the MSB (MSB=1).
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + PW'(Q_in[i]);
    low_ones  = '0;
    high_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      low_ones[i]  = (PW'(i) < pop);
      high_ones[i] = (PW'(i) >= (PW'(WIDTH) - pop));
    end
    if (Q_in[WIDTH-1]) begin
      code_ok = (Q_in == high_ones);
      idx     = IW'(NPH - 32'(pop));
    end else begin
      code_ok = (Q_in == low_ones);
      idx     = IW'(pop);
    end
  end

  // Step classification relative to the last legal index, modulo 2*WIDTH.
  always_comb begin
    idx_fwd = (Count == LAST_IDX) ? '0 : Count + IW'(1);
    idx_rev = (Count == '0) ? LAST_IDX : Count - IW'(1);
    is_fwd  = (idx == idx_fwd);
    is_rev  = (idx == idx_rev);
    is_hold = (idx == Count);
  end

  always_comb begin
    state_nxt  = state;
    step_nxt   = step_cnt;
    count_nxt  = Count;
    cvalid_nxt = Count_valid;
    dir_nxt    = Dir;
    ill_nxt    = 1'b0;
    seq_nxt    = 1'b0;
    err_inc    = 1'b0;
`ifdef JDEC_STALL_TIMEOUT_EN
    stall_nxt  = stall_cnt;
`endif
    if (In_valid) begin
      if (!code_ok) begin
        ill_nxt    = 1'b1;
        cvalid_nxt = 1'b0;
        err_inc    = 1'b1;
        step_nxt   = '0;
        state_nxt  = UNLOCKED;
`ifdef JDEC_STALL_TIMEOUT_EN
        stall_nxt  = '0;
`endif
      end else begin
        count_nxt  = idx;
        cvalid_nxt = 1'b1;
        case (state)
          UNLOCKED: begin
            step_nxt  = '0;
            state_nxt = TRACKING;
          end
          TRACKING: begin
            if (is_fwd || is_rev) begin
              dir_nxt = is_fwd;
              if (step_cnt != '0 && is_fwd == Dir) step_nxt = step_cnt + SW'(1);
              else                                 step_nxt = SW'(1);
              if (step_nxt == SW'(LOCK_COUNT)) state_nxt = LOCKED;
            end else if (!is_hold) begin
              seq_nxt  = 1'b1;
              err_inc  = 1'b1;
              step_nxt = '0;
            end
          end
          LOCKED: begin
            if (is_hold) begin
`ifdef JDEC_STALL_TIMEOUT_EN
              stall_nxt = stall_cnt + TW'(1);
              if (stall_nxt == TW'(STALL_LIMIT)) begin
                stall_nxt = '0;
                step_nxt  = '0;
                state_nxt = TRACKING;
              end
`endif
            end else if ((is_fwd && Dir) || (is_rev && !Dir)) begin
`ifdef JDEC_STALL_TIMEOUT_EN
              stall_nxt = '0;
`endif
            end else begin
              // Direction reversal or skip breaks lock; a reversal still reports its direction.
              if (is_fwd || is_rev) dir_nxt = is_fwd;
              seq_nxt   = 1'b1;
              err_inc   = 1'b1;
              step_nxt  = '0;
              state_nxt = TRACKING;
`ifdef JDEC_STALL_TIMEOUT_EN
              stall_nxt = '0;
`endif
            end
          end
          default: state_nxt = UNLOCKED;
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state        <= UNLOCKED;
      step_cnt     <= '0;
      Count        <= '0;
      Count_valid  <= 1'b0;
      Dir          <= 1'b1;
      Illegal_code <= 1'b0;
      Seq_error    <= 1'b0;
      Locked       <= 1'b0;
      Err_count    <= '0;
`ifdef JDEC_STALL_TIMEOUT_EN
      stall_cnt    <= '0;
`endif
    end else begin
      state        <= state_nxt;
      step_cnt     <= step_nxt;
      Count        <= count_nxt;
      Count_valid  <= cvalid_nxt;
      Dir          <= dir_nxt;
      Illegal_code <= ill_nxt;
      Seq_error    <= seq_nxt;
      Locked       <= (state_nxt == LOCKED);
      if (err_inc && Err_count != 8'hFF) Err_count <= Err_count + 8'd1;
`ifdef JDEC_STALL_TIMEOUT_EN
      stall_cnt    <= stall_nxt;
`endif
    end
  end

endmodule
